// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder for the RV64 data memory
// Optional build macro DATA_MEM_MISALIGN_CHECK_EN: fault misaligned accesses instead of aligning them down.
module data_mem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state;
  stateT       nextState;
  logic [3:0]  cnt;
  logic        accept;

  logic        weQ;
  logic [63:0] addrQ;
  logic [2:0]  sizeQ;
  logic [63:0] wdataQ;

  logic        curWe;
  logic [63:0] curAddr;
  logic [2:0]  curSize;
  logic [63:0] curWdata;

  logic [63:0]   off;
  logic [AW-1:0] wordIdx;
  logic [2:0]    lane;
  logic [2:0]    laneEff;
  logic          rangeErr;
  logic          sizeErr;
  logic          accErr;

  logic [63:0] memWord;
  logic [63:0] shifted;
  logic [63:0] loadData;
  logic [7:0]  sizeMask;
  logic [7:0]  byteEn;
  logic [63:0] storeData;
  logic        enterResp;
  logic        doWrite;

  logic [63:0] rdataQ;
  logic        errQ;

  logic [63:0] mem [DEPTH_WORDS];

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access resolves on the accept edge, before the capture registers load.
  always_comb begin
    curWe    = weQ;
    curAddr  = addrQ;
    curSize  = sizeQ;
    curWdata = wdataQ;
    if (state == IDLE) begin
      curWe    = req_we;
      curAddr  = req_addr;
      curSize  = req_size;
      curWdata = req_wdata;
    end
  end

  always_comb begin
    off      = curAddr - BASE_ADDR;
    rangeErr = |off[63:AW+3];
    wordIdx  = off[AW+2:3];
    lane     = off[2:0];
    sizeErr  = (curSize == 3'b111) || (curWe && curSize[2]);
    laneEff  = lane;
    sizeMask = 8'h01;
    case (curSize[1:0])
      2'd0: begin laneEff = lane;                sizeMask = 8'h01; end
      2'd1: begin laneEff = {lane[2:1], 1'b0};   sizeMask = 8'h03; end
      2'd2: begin laneEff = {lane[2], 2'b00};    sizeMask = 8'h0F; end
      default: begin laneEff = 3'd0;             sizeMask = 8'hFF; end
    endcase
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    accErr = rangeErr || sizeErr || (laneEff != lane);
`else
    accErr = rangeErr || sizeErr;
`endif
  end

  always_comb begin
    memWord   = mem[wordIdx];
    shifted   = memWord >> {laneEff, 3'b000};
    byteEn    = sizeMask << laneEff;
    storeData = curWdata << {laneEff, 3'b000};
    case (curSize)
      3'b000:  loadData = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  loadData = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  loadData = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  loadData = shifted;
      3'b100:  loadData = {56'd0, shifted[7:0]};
      3'b101:  loadData = {48'd0, shifted[15:0]};
      3'b110:  loadData = {32'd0, shifted[31:0]};
      default: loadData = 64'd0;
    endcase
  end

  // Stores commit on the RESP-entry edge, and only if reset is released on that edge.
  assign enterResp = (nextState == RESP) && (state != RESP);
  assign doWrite   = enterResp && reset && curWe && !accErr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          nextState = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset && (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdataQ;
    rsp_err   = errQ;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= 64'd0;
      sizeQ  <= 3'd0;
      wdataQ <= 64'd0;
      rdataQ <= 64'd0;
      errQ   <= 1'b0;
    end else begin
      if (accept) begin
        weQ    <= req_we;
        addrQ  <= req_addr;
        sizeQ  <= req_size;
        wdataQ <= req_wdata;
        cnt    <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enterResp) begin
        rdataQ <= (curWe || accErr) ? 64'd0 : loadData;
        errQ   <= accErr;
      end else if (state == RESP && rsp_ready) begin
        rdataQ <= 64'd0;
        errQ   <= 1'b0;
      end
    end
  end

  // Memory array has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < 8; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and random load/store checks against a byte-level memory model
module tb_data_mem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int DEPTH = 4096;
  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] lastRd;
  logic        lastErr;
  logic [7:0]  mdl [longint unsigned];

  data_mem_responder #(
    .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, natural-size accesses.
  function automatic void refModel(input bit we, input logic [63:0] addr, input logic [2:0] size,
                                   input logic [63:0] wd, output logic [63:0] rd, output bit err);
    longint unsigned o;
    int n;
    o = addr - BASE;
    n = 1 << size[1:0];
    rd = 64'd0;
    err = 0;
    if (o >= 64'(8 * DEPTH)) err = 1;
    if (size == 3'b111) err = 1;
    if (we && size >= 3'b100) err = 1;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if ((o % longint'(n)) != 0) err = 1;
`endif
    if (err) return;
    o = o - (o % longint'(n));
    if (we) begin
      for (int i = 0; i < n; i++) mdl[o + longint'(i)] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (64'(mdl[o + longint'(i)]) << (8 * i));
      if (size < 3'b011 && rd[8*n-1]) rd = rd | (~64'd0 << (8 * n));
    end
  endfunction

  task automatic access(input bit we, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    rd  = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_rdata", rsp_rdata, rd);
      chk("hold_rsp_err", 64'(rsp_err), 64'(err));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit we, input logic [63:0] addr, input logic [2:0] size,
                     input logic [63:0] wd, input int hold, input string tag);
    logic [63:0] erd;
    bit eerr;
    logic [63:0] rd;
    logic e;
    int lat;
    refModel(we, addr, size, wd, erd, eerr);
    access(we, addr, size, wd, hold, rd, e, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 64'(e), 64'(eerr));
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    lastRd  = rd;
    lastErr = e;
  endtask

  initial begin
    int guard;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 64'd0;
    req_size  = 3'd0;
    req_wdata = 64'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_rsp_rdata", rsp_rdata, 64'd0);
    chk("idle_rsp_err", 64'(rsp_err), 64'd0);

    for (int w = 0; w < 8; w++) run(1'b1, BASE + 64'(8 * w), 3'b011, {$urandom, $urandom}, 0, "init");

    run(1'b1, 64'h8000_0008, 3'b011, 64'h8877_6655_4433_2211, 0, "SD");
    run(1'b0, 64'h8000_0008, 3'b011, 64'd0, 0, "LD");
    chk("LD_value", lastRd, 64'h8877_6655_4433_2211);
    chk("LD_errflag", 64'(lastErr), 64'd0);
    run(1'b0, 64'h8000_000F, 3'b000, 64'd0, 0, "LB");
    chk("LB_value", lastRd, 64'hFFFF_FFFF_FFFF_FF88);
    run(1'b0, 64'h8000_000F, 3'b100, 64'd0, 0, "LBU");
    chk("LBU_value", lastRd, 64'h88);
    run(1'b0, 64'h8000_000C, 3'b010, 64'd0, 0, "LW");
    chk("LW_value", lastRd, 64'hFFFF_FFFF_8877_6655);
    run(1'b0, 64'h8000_000C, 3'b110, 64'd0, 0, "LWU");
    chk("LWU_value", lastRd, 64'h8877_6655);
    run(1'b1, 64'h8000_000A, 3'b001, 64'hBEEF, 0, "SH");
    run(1'b0, 64'h8000_0008, 3'b011, 64'd0, 5, "LD_hold");
    chk("SH_merge_value", lastRd, 64'h8877_6655_BEEF_2211);

    run(1'b0, 64'h7FFF_FFF8, 3'b011, 64'd0, 0, "LD_below");
    chk("below_errflag", 64'(lastErr), 64'd1);
    chk("below_value", lastRd, 64'd0);
    run(1'b0, 64'h8000_8000, 3'b011, 64'd0, 0, "LD_above");
    chk("above_errflag", 64'(lastErr), 64'd1);
    chk("above_value", lastRd, 64'd0);

    run(1'b1, 64'h8000_0000, 3'b011, 64'h0123_4567_89AB_CDEF, 0, "SD0");
    run(1'b0, 64'h8000_0001, 3'b001, 64'd0, 0, "LH_mis");
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    chk("LH_mis_errflag", 64'(lastErr), 64'd1);
    chk("LH_mis_value", lastRd, 64'd0);
`else
    chk("LH_mis_errflag", 64'(lastErr), 64'd0);
    chk("LH_mis_value", lastRd, 64'hFFFF_FFFF_FFFF_CDEF);
`endif

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h8000_0008;
    req_size  = 3'b011;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rst_req_ready", 64'(req_ready), 64'd0);
    chk("abort_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_after_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    run(1'b0, 64'h8000_0008, 3'b011, 64'd0, 0, "LD_after_abort");
    chk("abort_no_write", lastRd, 64'h8877_6655_BEEF_2211);

    for (int k = 0; k < 150; k++) begin
      bit          we;
      logic [2:0]  sz;
      logic [63:0] a;
      logic [63:0] d;
      int          hold;
      we = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       a = BASE - 64'd8 + 64'($urandom_range(0, 7));
        1:       a = BASE + 64'h8000 + 64'($urandom_range(0, 7));
        default: a = BASE + 64'($urandom_range(0, 63));
      endcase
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      run(we, a, sz, d, hold, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
